// File: rtl/mso_cic_pkg.sv
// Shared limits and helpers for the multichannel CIC comb cascade.
package mso_cic_pkg;

  localparam int MAX_N = 8;
  localparam int MAX_D = 4;
  localparam int MAX_C = 16;

  function automatic int ch_width(input int c);
    return (c > 1) ? $clog2(c) : 1;
  endfunction

  // Half of one output LSB, expressed at the internal width; zero when no bits are dropped.
  function automatic longint unsigned round_const(input int w, input int out_w);
    return (w > out_w) ? (64'd1 << (w - out_w - 1)) : 64'd0;
  endfunction

endpackage

// File: rtl/cic_comb_mc_stage.sv
// One multichannel comb stage: y[n] = x[n] - x[n-D] per channel, one register deep.
module cic_comb_mc_stage
  import mso_cic_pkg::*;
#(
  parameter int D = 1,
  parameter int C = 1,
  parameter int W = 24,
  localparam int CW = ch_width(C)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CW-1:0]        in_ch,
  input  logic signed [W-1:0]  in_x,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic signed [W-1:0]  out_x
);

  logic signed [W-1:0] hist [C][D];
  logic signed [W-1:0] oldest;
  logic [C-1:0]        hit;

  // Only in-range channels can raise a hit, so out-of-range indices behave as bubbles.
  always_comb begin
    oldest = '0;
    hit    = '0;
    for (int c = 0; c < C; c++) begin
      if (in_ch == CW'(c)) begin
        oldest = hist[c][D-1];
        hit[c] = in_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < C; c++) begin
        for (int k = 0; k < D; k++) begin
          hist[c][k] <= '0;
        end
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_x     <= '0;
    end else begin
      out_valid <= |hit;
      out_ch    <= in_ch;
      out_x     <= in_x - oldest;
      for (int c = 0; c < C; c++) begin
        if (hit[c]) begin
          hist[c][0] <= in_x;
          for (int k = 1; k < D; k++) begin
            hist[c][k] <= hist[c][k-1];
          end
        end
      end
    end
  end

endmodule

// File: rtl/cic_comb_cascade.sv
// N-stage multichannel CIC comb cascade with registered MSB-reduced output.
// Define CIC_COMB_ROUND_EN for round-half-up output reduction; default is truncation.
module cic_comb_cascade
  import mso_cic_pkg::*;
#(
  parameter int N     = 3,
  parameter int D     = 1,
  parameter int C     = 1,
  parameter int W     = 24,
  parameter int OUT_W = 12,
  localparam int CW   = ch_width(C)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CW-1:0]           in_ch,
  input  logic signed [W-1:0]     in_x,
  output logic                    out_valid,
  output logic [CW-1:0]           out_ch,
  output logic signed [OUT_W-1:0] out_y
);

  localparam int SH = W - OUT_W;

`ifdef CIC_COMB_ROUND_EN
  localparam logic [W-1:0] RND = W'(round_const(W, OUT_W));
`else
  localparam logic [W-1:0] RND = '0;
`endif

  logic [N:0]               vld;
  logic [N:0][CW-1:0]       ch;
  logic [N:0][W-1:0]        dat;

  assign vld[0] = in_valid;
  assign ch[0]  = in_ch;
  assign dat[0] = in_x;

  for (genvar s = 0; s < N; s++) begin : g_stage
    cic_comb_mc_stage #(
      .D (D),
      .C (C),
      .W (W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vld[s]),
      .in_ch     (ch[s]),
      .in_x      (dat[s]),
      .out_valid (vld[s+1]),
      .out_ch    (ch[s+1]),
      .out_x     (dat[s+1])
    );
  end

  // The rounding add wraps at W bits, so the kept MSBs wrap modulo 2^OUT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_y     <= '0;
    end else begin
      out_valid <= vld[N];
      out_ch    <= ch[N];
      out_y     <= OUT_W'((dat[N] + RND) >> SH);
    end
  end

endmodule

// File: tb/tb_cic_comb_cascade.sv
// Scoreboard bench for cic_comb_cascade (N=2, D=2, C=3, W=16, OUT_W=12).
module tb_cic_comb_cascade;

  localparam int N     = 2;
  localparam int D     = 2;
  localparam int C     = 3;
  localparam int W     = 16;
  localparam int OUT_W = 12;
  localparam int CW    = 2;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic [CW-1:0]           in_ch = '0;
  logic signed [W-1:0]     in_x = '0;
  logic                    out_valid;
  logic [CW-1:0]           out_ch;
  logic signed [OUT_W-1:0] out_y;

  typedef struct {
    int                      due;
    logic [CW-1:0]           ch;
    logic signed [OUT_W-1:0] y;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic signed [W-1:0] mh [N][C][D];

  cic_comb_cascade #(
    .N(N), .D(D), .C(C), .W(W), .OUT_W(OUT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [OUT_W-1:0] reduceModel(input logic signed [W-1:0] v);
    logic [W-1:0] t;
`ifdef CIC_COMB_ROUND_EN
    t = v + 16'd8;
`else
    t = v;
`endif
    return t[W-1:W-OUT_W];
  endfunction

  task automatic clearModel();
    for (int s = 0; s < N; s++)
      for (int c = 0; c < C; c++)
        for (int k = 0; k < D; k++)
          mh[s][c][k] = '0;
  endtask

  task automatic runModel(input int c, input logic signed [W-1:0] x,
                          output logic signed [OUT_W-1:0] y);
    logic signed [W-1:0] v;
    logic signed [W-1:0] d;
    v = x;
    for (int s = 0; s < N; s++) begin
      d = v - mh[s][c][D-1];
      for (int k = D-1; k > 0; k--) mh[s][c][k] = mh[s][c][k-1];
      mh[s][c][0] = v;
      v = d;
    end
    y = reduceModel(v);
  endtask

  task automatic applyStimulus(input logic v, input logic [CW-1:0] c,
                               input logic signed [W-1:0] x,
                               input bit use_const, input logic signed [OUT_W-1:0] const_y);
    exp_t e;
    logic signed [OUT_W-1:0] m;
    @(negedge clk);
    in_valid = v;
    in_ch    = c;
    in_x     = x;
    if (v && int'(c) < C) begin
      runModel(int'(c), x, m);
      e.due = cyc + N + 1;
      e.ch  = c;
      e.y   = use_const ? const_y : m;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    clearModel();
    #1;
    checkOutput("rst_valid", longint'(out_valid), 0);
    checkOutput("rst_ch", longint'(out_ch), 0);
    checkOutput("rst_y", longint'(out_y), 0);
    repeat (2) @(negedge clk);
    checkOutput("rst_hold_valid", longint'(out_valid), 0);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("latency", longint'(cyc), longint'(e.due));
        checkOutput("out_ch", longint'(out_ch), longint'(e.ch));
        checkOutput("out_y", longint'(out_y), longint'(e.y));
      end
    end
  end

  initial begin
    doReset();

    // Impulse on ch0: (1 - z^-2)^2 scaled by 1/16.
    applyStimulus(1'b1, 2'd0, 16'sd16, 1'b1, 12'sd1);
    applyStimulus(1'b1, 2'd0, 16'sd0,  1'b1, 12'sd0);
    applyStimulus(1'b1, 2'd0, 16'sd0,  1'b1, -12'sd2);
    applyStimulus(1'b1, 2'd0, 16'sd0,  1'b1, 12'sd0);
    applyStimulus(1'b1, 2'd0, 16'sd0,  1'b1, 12'sd1);
    applyStimulus(1'b1, 2'd0, 16'sd0,  1'b1, 12'sd0);
    idle(N + 2);

    // Interleaved steps on ch1/ch2 with gaps and an out-of-range channel.
    doReset();
    applyStimulus(1'b1, 2'd1, 16'sd160, 1'b1, 12'sd10);
    applyStimulus(1'b1, 2'd2, 16'sd32,  1'b1, 12'sd2);
    idle(1);
    applyStimulus(1'b1, 2'd3, 16'sd999, 1'b0, '0);
    applyStimulus(1'b1, 2'd1, 16'sd160, 1'b1, 12'sd10);
    applyStimulus(1'b1, 2'd2, 16'sd32,  1'b1, 12'sd2);
    idle(3);
    applyStimulus(1'b1, 2'd1, 16'sd160, 1'b1, -12'sd10);
    applyStimulus(1'b1, 2'd2, 16'sd32,  1'b1, -12'sd2);
    applyStimulus(1'b1, 2'd1, 16'sd160, 1'b1, -12'sd10);
    applyStimulus(1'b1, 2'd2, 16'sd32,  1'b1, -12'sd2);
    applyStimulus(1'b1, 2'd1, 16'sd160, 1'b1, 12'sd0);
    applyStimulus(1'b1, 2'd0, 16'sd16,  1'b1, 12'sd1);
    idle(N + 2);

    // Reset with samples in flight; the first sample afterwards sees zero history.
    applyStimulus(1'b1, 2'd0, 16'sd160, 1'b0, '0);
    applyStimulus(1'b1, 2'd1, 16'sd320, 1'b0, '0);
    doReset();
    applyStimulus(1'b1, 2'd0, 16'sd160, 1'b1, 12'sd10);
    idle(N + 3);

    // Full-scale values exercise modulo wrap-around.
    doReset();
    applyStimulus(1'b1, 2'd2, 16'sd32767,  1'b0, '0);
    applyStimulus(1'b1, 2'd2, -16'sd32768, 1'b0, '0);
    applyStimulus(1'b1, 2'd2, 16'sd32767,  1'b0, '0);
    applyStimulus(1'b1, 2'd2, -16'sd32768, 1'b0, '0);
    applyStimulus(1'b1, 2'd2, -16'sd32768, 1'b0, '0);
    applyStimulus(1'b1, 2'd2, 16'sd32767,  1'b0, '0);
    applyStimulus(1'b1, 2'd2, 16'sd0,      1'b0, '0);
    idle(N + 2);

    // Random traffic with a reset in the middle.
    doReset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) doReset();
      applyStimulus(($urandom_range(0, 9) < 7), CW'($urandom_range(0, 3)),
                    W'($urandom), 1'b0, '0);
    end
    idle(N + 4);
    checkOutput("drain", longint'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cic_comb_cascade.md
CIC_COMB_CASCADE -- requirements
Module: cic_comb_cascade

Interface
REQ-001 SHALL have parameter N, default 3: number of cascaded comb stages (1..8).
REQ-002 SHALL have parameter D, default 1: differential delay per stage, in samples (1..4).
REQ-003 SHALL have parameter C, default 1: number of time-multiplexed channels (1..16).
REQ-004 SHALL have parameter W, default 24: internal and input data width, two's complement.
REQ-005 SHALL have parameter OUT_W, default 12: output width (OUT_W <= W); the MSBs are kept.
REQ-006 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: qualifies in_x and in_ch for the current cycle.
REQ-009 SHALL have port in_ch, input, max(1,$clog2(C)): channel index of the input sample.
REQ-010 SHALL have port in_x, input, W, signed: input sample, normally at the decimated integrator rate.
REQ-011 SHALL have port out_valid, output, 1: qualifies out_ch and out_y.
REQ-012 SHALL have port out_ch, output, max(1,$clog2(C)): channel tag carried with the sample.
REQ-013 SHALL have port out_y, output, OUT_W, signed: filtered sample.

Function
REQ-014 Each stage SHALL compute y[n] = x[n] - x[n-D] per channel in modulo-2^W arithmetic; wrap-around is intentional, with no saturation.
REQ-015 Each stage SHALL be one register deep; out_valid SHALL assert exactly N+1 cycles after the in_valid that produced it (N stages plus output register).
REQ-016 The pipeline SHALL advance every cycle; there is no backpressure. Bubbles (in_valid=0) SHALL propagate as out_valid=0.
REQ-017 The per-channel delay history SHALL advance only on a valid sample for that channel; other channels' histories SHALL be unaffected.
REQ-018 The channel tag SHALL travel alongside its data through every stage.
REQ-019 Channel order is arbitrary; any channel may follow any other, including the same channel back-to-back.
REQ-020 An in_ch value >= C SHALL be ignored: it is treated as in_valid=0.
REQ-021 Histories SHALL be held in registers indexed [stage][channel][tap]: N*C*D words of W bits.
REQ-022 Output reduction from W to OUT_W SHALL follow REQ-026/REQ-027 and apply to the output register only.

Reset
REQ-023 While rst=1, all history words, pipeline data, and channel tags SHALL be 0, and out_valid, out_ch, and out_y SHALL be 0.
REQ-024 Assertion of rst mid-stream SHALL discard in-flight samples; no stale out_valid SHALL appear after deassertion.
REQ-025 The first sample after reset SHALL see zero history (x[n-D]=0).

Configuration
REQ-026 With CIC_COMB_ROUND_EN defined, the output SHALL be rounded half-up: add 2^(W-OUT_W-1), then drop W-OUT_W LSBs, with the result wrapping modulo 2^OUT_W. When W==OUT_W, no addition is made.
REQ-027 Without CIC_COMB_ROUND_EN, the output SHALL be truncated (the W-OUT_W LSBs dropped, i.e. floor).

Structure
REQ-028 The shared package mso_cic_pkg SHALL hold the channel-index width function, the maximum N/D/C limits, and the rounding-constant helper.
REQ-029 One sub-module, cic_comb_mc_stage, SHALL implement a single multichannel stage with parameters D, C, W and a valid/channel/data in/out interface. The top level SHALL instantiate it N times plus the output reduction register.

Verification
REQ-030 Config N=1, D=1, C=1, W=OUT_W=12; inputs 0,100,100,100 valid on consecutive cycles -> out_y 0,100,0,0, with out_valid 2 cycles after each input.
REQ-031 Config N=3, D=1, C=1; impulse 1 followed by zeros -> out_y 1,-3,3,-1,0,0.
REQ-032 Config C=2, N=1, D=1; interleaved ch0 inputs 0,10,20 and ch1 inputs 7,7,7 -> ch0 outputs 0,10,10 and ch1 outputs 7,0,0, with out_ch matching.
REQ-033 Config W=OUT_W=8, N=1; inputs -128 then 127 -> second output is -1 (wrap of 255).
REQ-034 Config N=2, gaps of 3 idle cycles between valid inputs 5,5,5 -> outputs 5,-5,0 in order; histories unchanged during gaps.
REQ-035 Config W=16, OUT_W=12; input 24 then rst pulsed mid-pipeline, then input 24 -> no output for the first sample. The post-reset output is 2 with CIC_COMB_ROUND_EN (24+8=32, >>4), and 1 without it (24>>4).
